// File: rtl/counter_snapshot_piso.sv
`default_nettype none
// ============================================================================
// Module   : counter_snapshot_piso
// Purpose  : Prescaled up/down counter with a sticky match flag, plus a
//            parallel-in/serial-out shift register that snapshots the counter
//            and shifts it out MSB first. The counter path and the shift path
//            run side by side on the same clock edge.
// Ports    : io_in[0]  clock (rising edge)
//            io_in[1]  reset, asynchronous, active-high
//            io_in[2]  en          - enables prescaler and counter
//            io_in[3]  dir         - 1 = count up, 0 = count down
//            io_in[4]  clr_match   - synchronous clear of sticky match
//            io_in[5]  reserved, ignored
//            io_in[6]  ser_in      - serial fill bit into shift-register LSB
//            io_in[7]  shift_nload - 0 = parallel load, 1 = shift
//            io_out[0] match, io_out[1] tick, io_out[5:2] count MSBs,
//            io_out[6] done, io_out[7] ser_out
// Revision : 1.0 - initial release
// ============================================================================
module counter_snapshot_piso #(
    parameter int               WIDTH     = 8,
    parameter int               DIV_LOG2  = 2,
    parameter logic [WIDTH-1:0] MATCH_VAL = {WIDTH{1'b1}}
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // bit_cnt must be able to hold the value WIDTH itself
    localparam int               BC_W    = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0]  C_BC_FULL = BC_W'(WIDTH);
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

    logic clk;
    logic rst;
    logic en;
    logic dir;
    logic clr_match;
    logic ser_in;
    logic shift_nload;
    logic w_unused_rsv;

    assign clk          = io_in[0];
    assign rst          = io_in[1];
    assign en           = io_in[2];
    assign dir          = io_in[3];
    assign clr_match    = io_in[4];
    assign w_unused_rsv = io_in[5];
    assign ser_in       = io_in[6];
    assign shift_nload  = io_in[7];

    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             match_q, match_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             done_q, done_d;

    // ------------------------------------------------------------------------
    // Prescaler: the step fires on the enabled edge where the prescaler is at
    // its terminal value. With no division the prescaler does not exist.
    // ------------------------------------------------------------------------
    generate
        if (DIV_LOG2 > 0) begin : g_pre
            logic [DIV_LOG2-1:0] pre_q, pre_d;

            always_comb begin
                pre_d = pre_q;
                if (en) begin
                    pre_d = pre_q + DIV_LOG2'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_d;
                end
            end

            assign step = en & (&pre_q);
        end else begin : g_nopre
            assign step = en;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Counter, tick and sticky match
    // ------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        tick_d  = step;
        match_d = match_q;
        if (step) begin
            count_d = dir ? (count_q + C_ONE) : (count_q - C_ONE);
        end
        // Setting on a match takes priority over a simultaneous clear
        if (step && (count_d == MATCH_VAL)) begin
            match_d = 1'b1;
        end else if (clr_match) begin
            match_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Snapshot shift register. A load captures the pre-edge count, so a load
    // coinciding with a count step sees the old value.
    // ------------------------------------------------------------------------
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        if (!shift_nload) begin
            shreg_d   = count_q;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end else if (bit_cnt_q < C_BC_FULL) begin
            shreg_d   = {shreg_q[WIDTH-2:0], ser_in};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            done_d    = (bit_cnt_q + BC_W'(1)) == C_BC_FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            tick_q    <= 1'b0;
            match_q   <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            tick_q    <= tick_d;
            match_q   <= match_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    // All outputs are direct register bits
    assign io_out = {shreg_q[WIDTH-1], done_q, count_q[WIDTH-1 -: 4], tick_q, match_q};

endmodule
`default_nettype wire

// File: tb/tb_counter_snapshot_piso.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_snapshot_piso
// Purpose  : Self-checking bench for counter_snapshot_piso. Two instances
//            (prescale by 4 and no prescale) share one input bus; a
//            behavioural model tracks both and is compared every cycle,
//            with directed scenarios and literal expectations on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_snapshot_piso;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, dir = 1'b0, clr = 1'b0, rsv = 1'b0, ser = 1'b0, shn = 1'b0;
    logic [7:0] io_in;
    logic [7:0] out0, out1;

    assign io_in = {shn, ser, rsv, clr, dir, en, rst, clk};

    counter_snapshot_piso u_dut0 (
        .io_in  (io_in),
        .io_out (out0)
    );

    counter_snapshot_piso #(.WIDTH(8), .DIV_LOG2(0), .MATCH_VAL(8'hFF)) u_dut1 (
        .io_in  (io_in),
        .io_out (out1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: plain integer arithmetic, one slot per instance
    // ------------------------------------------------------------------------
    int m_pre[2], m_cnt[2], m_sh[2], m_bc[2];
    bit m_tick[2], m_match[2], m_done[2];
    int div[2] = '{4, 1};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pre[k] = 0; m_cnt[k] = 0; m_sh[k] = 0; m_bc[k] = 0;
                m_tick[k] = 0; m_match[k] = 0; m_done[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int old_cnt;
                bit st;
                old_cnt = m_cnt[k];
                st = en && (m_pre[k] == div[k] - 1);
                if (en) m_pre[k] = (m_pre[k] + 1) % div[k];
                if (st) m_cnt[k] = (old_cnt + (dir ? 1 : 255)) % 256;
                m_tick[k] = st;
                if (st && m_cnt[k] == 255) m_match[k] = 1;
                else if (clr) m_match[k] = 0;
                if (!shn) begin
                    m_sh[k] = old_cnt; m_bc[k] = 0; m_done[k] = 0;
                end else if (m_bc[k] < 8) begin
                    m_sh[k] = ((m_sh[k] << 1) | int'(ser)) & 255;
                    m_bc[k] = m_bc[k] + 1;
                    m_done[k] = (m_bc[k] == 8);
                end
            end
        end
    end

    function automatic logic [7:0] mexp(input int k);
        int c, s;
        c = m_cnt[k];
        s = m_sh[k];
        return {s[7], m_done[k], c[7:4], m_tick[k], m_match[k]};
    endfunction

    // Compare process: outputs checked against the model every cycle
    always @(negedge clk) begin
        chk("model_div4", out0, mexp(0));
        chk("model_div1", out1, mexp(1));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_out0", out0, 8'h00);
        chk("reset_out1", out1, 8'h00);
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq;
        #1;
        // Up-count with prescale 4: tick after edges 4, 8, 12, 16
        do_reset();
        en = 1; dir = 1; shn = 1; ser = 0;
        for (int e = 1; e <= 16; e++) begin
            step(1);
            chk("up_tick", {7'b0, out0[1]}, {7'b0, (e % 4) == 0});
        end
        chk("up_msb0", {4'b0, out0[5:2]}, 8'h00);
        chk("up_model_cnt0", 8'(m_cnt[0]), 8'd4);
        chk("up_msb1", {4'b0, out1[5:2]}, 8'h01);
        chk("up_model_cnt1", 8'(m_cnt[1]), 8'd16);

        // Down wrap to 0xFF sets match; clear; clear with re-hit keeps it set
        do_reset();
        en = 1; dir = 0; shn = 1;
        step(4);
        chk("down_match", {7'b0, out0[0]}, 8'h01);
        chk("down_msb", {4'b0, out0[5:2]}, 8'h0F);
        en = 0; clr = 1;
        step(1);
        clr = 0;
        chk("clr_match", {7'b0, out0[0]}, 8'h00);
        en = 1; dir = 1;
        step(4);
        dir = 0;
        step(3);
        clr = 1;
        step(1);
        clr = 0;
        chk("set_wins", {7'b0, out0[0]}, 8'h01);

        // Snapshot 0xA5 on the undivided instance and shift it out
        do_reset();
        en = 1; dir = 1; shn = 0;
        step(165);
        en = 0;
        step(1);
        shn = 1; ser = 0;
        seq = 8'hA5;
        chk("ser_bit7", {7'b0, out1[7]}, {7'b0, seq[7]});
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk("ser_bit", {7'b0, out1[7]}, {7'b0, seq[7-i]});
            chk("not_done", {7'b0, out1[6]}, 8'h00);
        end
        step(1);
        chk("done_8th", out1[7:6], 8'h01);
        step(3);
        chk("done_hold", out1[7:6], 8'h01);

        // Freeze mid-prescale: counter path holds, shift path keeps going
        do_reset();
        en = 1; shn = 0;
        step(2);
        en = 0; shn = 1; ser = 1;
        step(10);
        chk("frz_tick", {7'b0, out0[1]}, 8'h00);
        chk("frz_msb", {4'b0, out0[5:2]}, 8'h00);
        chk("frz_model_pre", 8'(m_pre[0]), 8'd2);
        chk("frz_shift", out0[7:6], 8'h03);
        en = 1;
        step(1);
        chk("frz_tick_a", {7'b0, out0[1]}, 8'h00);
        step(1);
        chk("frz_tick_b", {7'b0, out0[1]}, 8'h01);

        // Load on the same edge as the 0x0F -> 0x10 step
        do_reset();
        en = 1; dir = 1; shn = 1; ser = 0;
        step(15);
        shn = 0;
        step(1);
        chk("cc_msb", {4'b0, out1[5:2]}, 8'h01);
        chk("cc_ser", {7'b0, out1[7]}, 8'h00);
        chk("cc_model_sh", 8'(m_sh[1]), 8'h0F);
        en = 0; shn = 1;
        step(4);
        chk("cc_ser4", {7'b0, out1[7]}, 8'h01);

        // Reset mid-operation with count 0x37 and 3 bits shifted
        do_reset();
        en = 1; dir = 1; shn = 0;
        step(55);
        en = 0; shn = 1;
        step(3);
        chk("pre_rst_msb", {4'b0, out1[5:2]}, 8'h03);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst1", out1, 8'h00);
        chk("async_rst0", out0, 8'h00);
        step(1);
        rst = 1'b0;

        // Randomized traffic with occasional asynchronous resets
        repeat (3000) begin
            en  = 1'($urandom_range(0, 3) != 0);
            dir = 1'($urandom);
            clr = 1'($urandom_range(0, 7) == 0);
            rsv = 1'($urandom);
            ser = 1'($urandom);
            shn = 1'($urandom_range(0, 9) != 0);
            rst = 1'($urandom_range(0, 99) == 0);
            step(1);
        end
        rst = 0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_snapshot_piso.md
COUNTER_SNAPSHOT_PISO -- requirements
Module: counter_snapshot_piso

Interface
- REQ-001: Parameter WIDTH, default 8: counter and shift-register width; legal range 4..16.
- REQ-002: Parameter DIV_LOG2, default 2: prescaler log2 divide; legal range 0..8; 0 means no division.
- REQ-003: Parameter MATCH_VAL, default all-ones (WIDTH bits): compare value for the match flag.
- REQ-004: io_in[0]  in  1  clock; all state is updated on its rising edge.
- REQ-005: io_in[1]  in  1  reset; one clock; reset is asynchronous and active-high.
- REQ-006: io_in[2]  in  1  en: enables the prescaler and counter.
- REQ-007: io_in[3]  in  1  dir: count direction, 1 = up, 0 = down.
- REQ-008: io_in[4]  in  1  clr_match: synchronous clear of the sticky match flag.
- REQ-009: io_in[5]  in  1  reserved; ignored.
- REQ-010: io_in[6]  in  1  ser_in: serial fill bit entering the shift-register LSB.
- REQ-011: io_in[7]  in  1  shift_nload: 0 = parallel load, 1 = shift.
- REQ-012: io_out[0]  out  1  match: sticky compare flag.
- REQ-013: io_out[1]  out  1  tick: registered pulse marking a counter update.
- REQ-014: io_out[5:2]  out  4  count[WIDTH-1:WIDTH-4]: counter MSBs.
- REQ-015: io_out[6]  out  1  done: WIDTH shifts completed since the last load.
- REQ-016: io_out[7]  out  1  ser_out = shreg[WIDTH-1].

Function
- REQ-017: Prescaler pre (DIV_LOG2 bits) SHALL increment, wrapping, on each edge with en=1, and hold when en=0.
- REQ-018: Step condition SHALL be en=1 and pre = 2^DIV_LOG2-1; with DIV_LOG2=0 it is en=1 alone.
- REQ-019: On a step, count SHALL become count+1 (dir=1) or count-1 (dir=0), modulo 2^WIDTH; count otherwise holds.
- REQ-020: tick SHALL be 1 for exactly the cycle following each counter update and 0 otherwise.
- REQ-021: match SHALL set on the edge where count is updated to MATCH_VAL and clear on an edge with clr_match=1; set wins when both occur on the same edge.
- REQ-022: With shift_nload=0, each edge SHALL load shreg <= count (pre-edge value), clear bit_cnt, and clear done.
- REQ-023: With shift_nload=1 and bit_cnt<WIDTH, each edge SHALL set shreg <= {shreg[WIDTH-2:0], ser_in} and increment bit_cnt.
- REQ-024: done SHALL set on the edge where bit_cnt reaches WIDTH; shreg, bit_cnt and done then hold until the next load.
- REQ-025: The counter/prescaler path and the shift path SHALL operate concurrently and independently on the same edge.
- REQ-026: All outputs SHALL be registered or direct register bits; no combinational path from io_in to io_out.

Reset
- REQ-027: While reset=1, pre, count, tick, match, shreg, bit_cnt and done SHALL be 0, independent of clock.
- REQ-028: Reset asserted mid-count or mid-shift SHALL zero all state immediately; after release, the first edge behaves as from power-up.

Verification
- REQ-029: Reset mid-operation: assert reset with count=0x37 and bit_cnt=3 -> io_out=0x00 immediately, with no clock edge required.
- REQ-030: Up-count: defaults, en=1, dir=1, 16 edges from reset -> count=4, tick high on cycles 5, 9, 13, 17, io_out[5:2]=0.
- REQ-031: Down wrap and match: DIV_LOG2=2, dir=0, 4 edges -> count=0xFF, match=1; clr_match=1 one edge -> match=0; clr_match asserted together with a re-hit -> match stays 1.
- REQ-032: Snapshot shift: DIV_LOG2=0, count to 0xA5 with en=1, then en=0, load, ser_in=0, shift:
  - ser_out sequence 1,0,1,0,0,1,0,1 (MSB first);
  - done=1 after the 8th shift;
  - extra shifts -> ser_out and done unchanged.
- REQ-033: Freeze: en=0 for 10 edges mid-prescale -> pre, count and tick unchanged; shift path still operates.
- REQ-034: Concurrent load/step: load on the same edge as a count step from 0x0F to 0x10 -> shreg=0x0F, count=0x10.
